// File: rtl/data_gen_pkg.sv
// Shared constants, state encodings and the PRBS-15 word step for the OOK frame source.
package data_gen_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LFSR_W = 15;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_SYNC    = 2'd1;
  localparam logic [ST_W-1:0] ST_PAYLOAD = 2'd2;

  localparam logic [WORD_W-1:0] DEF_SYNC_WORD = 16'hEB90;
  localparam logic [LFSR_W-1:0] DEF_PRBS_SEED = 15'h7FFF;

  // x^15 + x^14 + 1
  localparam int unsigned TAP_HI = 14;
  localparam int unsigned TAP_LO = 13;

  typedef struct packed {
    logic [LFSR_W-1:0] state;
    logic [WORD_W-1:0] word;
  } prbs_step_t;

  // Sixteen unrolled LFSR steps; the first generated bit lands in the word MSB.
  function automatic prbs_step_t prbs15_advance(input logic [LFSR_W-1:0] s_in);
    prbs_step_t r;
    logic [LFSR_W-1:0] s;
    logic nb;
    s  = s_in;
    r  = '0;
    nb = 1'b0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      nb     = s[TAP_HI] ^ s[TAP_LO];
      r.word = {r.word[WORD_W-2:0], nb};
      s      = {s[LFSR_W-2:0], nb};
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/data_gen_prbs15_word.sv
// PRBS-15 generator register: loads the seed or advances 16 steps per cycle.
module prbs15_word
  import data_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_PRBS_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              advance_i,
  output logic [WORD_W-1:0] word_c_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  prbs_step_t        step_c;

  always_comb begin
    step_c = prbs15_advance(lfsr_q);
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (advance_i) begin
      lfsr_d = step_c.state;
    end
  end

  assign word_c_o = step_c.word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/data_gen.sv
// Frame source: SYNC_WORD followed by PRBS_LENGTH PRBS-15 words, repeated while enabled.
module data_gen
  import data_gen_pkg::*;
#(
  parameter int unsigned       PRBS_LENGTH = 64,
  parameter logic [WORD_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter logic [LFSR_W-1:0] PRBS_SEED   = DEF_PRBS_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_enable,
  output logic [WORD_W-1:0] data_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PRBS_LENGTH - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              load_c, advance_c;
  logic [WORD_W-1:0] prbs_word_c;

  prbs15_word #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (load_c),
    .advance_i (advance_c),
    .word_c_o  (prbs_word_c)
  );

  // Next-state and output decode; the frame always runs to completion once started.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = '0;
    load_c    = 1'b0;
    advance_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send_enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        data_d  = SYNC_WORD;
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data_d    = prbs_word_c;
        advance_c = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = send_enable ? ST_SYNC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_data_gen.sv
// Directed bench for data_gen: frame structure, PRBS contents, early disable, reset abort, 1-word frames.
module tb_data_gen;

  localparam int unsigned LEN = 20;

  logic        clk;
  logic        rst;
  logic        en;
  logic        en1;
  logic [15:0] data_out;
  logic [15:0] data_out1;

  int checks;
  int errors;
  logic [15:0] frame0 [LEN];

  data_gen #(.PRBS_LENGTH(LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .send_enable (en),
    .data_out    (data_out)
  );

  data_gen #(.PRBS_LENGTH(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .send_enable (en1),
    .data_out    (data_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRBS-15 (x^15+x^14+1, seed 7FFF): payload word idx of a frame, MSB first.
  function automatic logic [15:0] model_word(input int idx);
    logic [14:0] r;
    logic [15:0] w;
    logic        b;
    r = 15'h7FFF;
    w = '0;
    for (int k = 0; k <= idx; k++) begin
      for (int j = 0; j < 16; j++) begin
        b = r[14] ^ r[13];
        r = {r[13:0], b};
        w = {w[14:0], b};
      end
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (data_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0000", i, data_out);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (data_out !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d got=%h exp=0000", i, data_out);
      end
    end
  endtask

  task automatic test_frames();
    en = 1'b1;
    step();
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL sync_latency got=%h exp=0000", data_out);
    end
    for (int f = 0; f < 3; f++) begin
      step();
      checks++;
      if (data_out !== 16'hEB90) begin
        errors++;
        $display("FAIL frame%0d_sync got=%h exp=eb90", f, data_out);
      end
      for (int w = 0; w < int'(LEN); w++) begin
        if (f == 2 && w == int'(LEN) - 1) en = 1'b0;
        step();
        checks++;
        if (data_out !== model_word(w)) begin
          errors++;
          $display("FAIL frame%0d_word%0d got=%h exp=%h", f, w, data_out, model_word(w));
        end
        if (f == 0) begin
          frame0[w] = data_out;
        end else begin
          checks++;
          if (data_out !== frame0[w]) begin
            errors++;
            $display("FAIL frame%0d_repeat_word%0d got=%h exp=%h", f, w, data_out, frame0[w]);
          end
        end
      end
      if (f == 0) begin
        checks++;
        if (frame0[0] !== 16'h0002) begin
          errors++;
          $display("FAIL first_payload got=%h exp=0002", frame0[0]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (data_out !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_frames cyc=%0d got=%h exp=0000", i, data_out);
      end
    end
  endtask

  task automatic test_drop_mid();
    en = 1'b1;
    step();
    step();
    checks++;
    if (data_out !== 16'hEB90) begin
      errors++;
      $display("FAIL drop_sync got=%h exp=eb90", data_out);
    end
    for (int w = 0; w < int'(LEN); w++) begin
      step();
      checks++;
      if (data_out !== model_word(w)) begin
        errors++;
        $display("FAIL drop_word%0d got=%h exp=%h", w, data_out, model_word(w));
      end
      if (w == 5) en = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (data_out !== 16'h0000) begin
        errors++;
        $display("FAIL drop_no_resync cyc=%0d got=%h exp=0000", i, data_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    en = 1'b1;
    step();
    step();
    for (int w = 0; w <= 10; w++) step();
    checks++;
    if (data_out !== model_word(10)) begin
      errors++;
      $display("FAIL pre_abort_word10 got=%h exp=%h", data_out, model_word(10));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL async_abort got=%h exp=0000", data_out);
    end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL restart_latency got=%h exp=0000", data_out);
    end
    step();
    checks++;
    if (data_out !== 16'hEB90) begin
      errors++;
      $display("FAIL restart_sync got=%h exp=eb90", data_out);
    end
    step();
    checks++;
    if (data_out !== 16'h0002) begin
      errors++;
      $display("FAIL restart_word0 got=%h exp=0002", data_out);
    end
    step();
    checks++;
    if (data_out !== model_word(1)) begin
      errors++;
      $display("FAIL restart_word1 got=%h exp=%h", data_out, model_word(1));
    end
    en = 1'b0;
    n = 0;
    while (data_out !== 16'h0000 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL restart_drain_timeout got=%h exp=0000", data_out);
    end
  endtask

  task automatic test_len1();
    logic [15:0] exp_seq [4];
    int n;
    exp_seq[0] = 16'hEB90;
    exp_seq[1] = 16'h0002;
    exp_seq[2] = 16'hEB90;
    exp_seq[3] = 16'h0002;
    en1 = 1'b1;
    step();
    checks++;
    if (data_out1 !== 16'h0000) begin
      errors++;
      $display("FAIL len1_latency got=%h exp=0000", data_out1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (data_out1 !== exp_seq[i]) begin
        errors++;
        $display("FAIL len1_seq%0d got=%h exp=%h", i, data_out1, exp_seq[i]);
      end
    end
    en1 = 1'b0;
    n = 0;
    while (data_out1 !== 16'h0000 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (data_out1 !== 16'h0000) begin
      errors++;
      $display("FAIL len1_drain_timeout got=%h exp=0000", data_out1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b0;
    en1    = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_frames();
    test_drop_mid();
    test_reset_mid();
    test_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
